// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and constants for the data-memory responder
// Purpose : state encoding, bus widths, default base address and the
//           request address check used by dm_responder.
// Ports   : none (package).
package mips_mem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;
    localparam logic [WORD_W-1:0] MEM_BASE = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // True when the byte address is misaligned or falls outside the window
    // [base, base + 4*depth). The subtraction wraps for addresses below base,
    // so one unsigned compare covers both ends of the window.
    function automatic logic access_err(
        input logic [WORD_W-1:0] addr,
        input logic [WORD_W-1:0] base,
        input int unsigned       depth
    );
        logic [WORD_W-1:0] off;
        logic [WORD_W:0]   span;
        off  = addr - base;
        span = {1'b0, WORD_W'(depth)} << 2;
        return (addr[1:0] != 2'b00) || ({1'b0, off} >= span);
    endfunction

endpackage

// File: rtl/dm_ram_array.sv
// rtl/dm_ram_array.sv - synchronous word RAM with per-byte write enables
// Purpose : storage behind dm_responder; one read and one write port, no reset.
// Ports   : clk           clock, all accesses on rising edge
//           i_we          write enable
//           i_waddr       write word index
//           i_wdata       write data
//           i_be          byte enables, i_be[i] selects i_wdata[8i+7:8i]
//           i_re          read enable; o_rdata holds its value when low
//           i_raddr       read word index
//           o_rdata       registered read data
module dm_ram_array
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [BE_W-1:0]   i_be,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (i_we && i_be[i]) begin
                r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - data-memory target for the MIPS MEM stage
// Purpose : accepts one word load/store at a time, waits WAIT_CYCLES, then
//           presents read data or a store acknowledge until rsp_ready.
// Ports   : clk        clock
//           reset      asynchronous active-low reset
//           req_valid  request present          req_ready  accept (IDLE only)
//           req_we     1=store 0=load           req_addr   byte address
//           req_wdata  store data               req_be     store byte enables
//           rsp_valid  response present         rsp_ready  core takes response
//           rsp_rdata  load word (0 otherwise)  rsp_err    misaligned/out of range
module dm_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned       DEPTH_WORDS = 1024,
    parameter int unsigned       WAIT_CYCLES = 2,
    parameter logic [WORD_W-1:0] BASE_ADDR   = MEM_BASE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_LAST = 4'(WAIT_CYCLES);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [AW-1:0]     r_idx;
    logic [WORD_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;
    logic              r_err;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic              r_rdata_en;

    logic              w_accept;
    logic              w_enter_resp;
    logic              w_leave_resp;
    logic [WORD_W-1:0] w_off;
    logic [AW-1:0]     w_idx;
    logic              w_ram_we;
    logic              w_ram_re;
    logic [WORD_W-1:0] w_ram_rdata;

    assign w_accept     = req_valid && (r_state == IDLE);
    // The first WAIT cycle is always spent, even with WAIT_CYCLES==0: it is the
    // address phase of the synchronous RAM, fed from the latched request.
    assign w_enter_resp = (r_state == WAIT) && (r_cnt == CNT_LAST);
    assign w_leave_resp = (r_state == RESP) && rsp_ready;

    assign w_off = req_addr - BASE_ADDR;
    assign w_idx = AW'(w_off >> 2);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (req_valid)    w_state_nxt = WAIT;
            WAIT:    if (w_enter_resp) w_state_nxt = RESP;
            RESP:    if (rsp_ready)    w_state_nxt = IDLE;
            default:                   w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= 4'd0;
        end else if ((r_state == WAIT) && !w_enter_resp) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // Request latch; the address check is resolved here so the RAM strobes
    // later depend only on registered state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_idx   <= w_idx;
            r_wdata <= req_wdata;
            r_be    <= req_be;
            r_err   <= access_err(req_addr, BASE_ADDR, DEPTH_WORDS);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rdata_en  <= 1'b0;
        end else if (w_enter_resp) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= r_err;
            r_rdata_en  <= !r_we && !r_err;
        end else if (w_leave_resp) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rdata_en  <= 1'b0;
        end
    end

    // Both strobes fire only on the edge entering RESP, so the RAM output
    // register holds the load word for as long as the response is stalled.
    assign w_ram_we = w_enter_resp && r_we && !r_err;
    assign w_ram_re = w_enter_resp && !r_we && !r_err;

    dm_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (r_idx),
        .i_wdata (r_wdata),
        .i_be    (r_be),
        .i_re    (w_ram_re),
        .i_raddr (r_idx),
        .o_rdata (w_ram_rdata)
    );

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rdata_en ? w_ram_rdata : '0;

endmodule
